// File: rtl/result_pkg.sv
// Shared sizes and FSM state type for the result collector.
package result_pkg;
    localparam int DATA_W = 64;
    localparam int CHUNKS = 8;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } collector_state_t;
endpackage

// File: rtl/result_collector_if.sv
// Bus between the output datapath / consumer and the result collector.
// Optional checksum signal is present only when RESULT_CHECKSUM_EN is defined.
interface result_collector_if
    import result_pkg::*;
#(
    parameter int DATA_W = result_pkg::DATA_W,
    parameter int CHUNKS = result_pkg::CHUNKS
);
    // Handshake: a chunk transfers on a rising edge where data_valid && data_ready.
    // data_ready depends only on registered state, never on data_valid; a chunk
    // offered without data_ready stays pending and is not consumed.
    logic                       start;
    logic [DATA_W-1:0]          data_in;
    logic                       data_valid;
    logic                       data_ready;
    logic [CNT_W-1:0]           chunk_count;
    logic                       busy;
    logic                       collect_done;
    logic                       result_valid;
    logic [CHUNKS*DATA_W-1:0]   result_flat;
    logic [ADDR_W-1:0]          rd_addr;
    logic [DATA_W-1:0]          rd_data;
    collector_state_t           dbg_state;
`ifdef RESULT_CHECKSUM_EN
    logic [DATA_W-1:0]          checksum;
`endif

    modport slave (
        input  start, data_in, data_valid, rd_addr,
        output data_ready, chunk_count, busy, collect_done, result_valid,
               result_flat, rd_data, dbg_state
`ifdef RESULT_CHECKSUM_EN
        , output checksum
`endif
    );

    modport master (
        output start, data_in, data_valid, rd_addr,
        input  data_ready, chunk_count, busy, collect_done, result_valid,
               result_flat, rd_data, dbg_state
`ifdef RESULT_CHECKSUM_EN
        , input checksum
`endif
    );
endinterface

// File: rtl/result_regfile.sv
// CHUNKS x DATA_W chunk storage: one write port, one registered read port,
// and the whole array exposed flat (chunk k in bits [DATA_W*k +: DATA_W]).
module result_regfile
    import result_pkg::*;
#(
    parameter int DATA_W = result_pkg::DATA_W,
    parameter int CHUNKS = result_pkg::CHUNKS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [ADDR_W-1:0]        raddr_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic [CHUNKS*DATA_W-1:0] flat_o
);
    logic [DATA_W-1:0] mem_q [CHUNKS];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < CHUNKS; k++) begin
                mem_q[k] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            rd_data_q <= mem_q[raddr_i];
        end
    end

    always_comb begin
        flat_o = '0;
        for (int k = 0; k < CHUNKS; k++) begin
            flat_o[k*DATA_W +: DATA_W] = mem_q[k];
        end
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/result_collector.sv
// Collects CHUNKS result chunks into storage and holds the assembled result.
// Define RESULT_CHECKSUM_EN to add an XOR checksum of the accepted chunks.
module result_collector
    import result_pkg::*;
#(
    parameter int DATA_W = result_pkg::DATA_W,
    parameter int CHUNKS = result_pkg::CHUNKS
) (
    input  logic               clk,
    input  logic               reset,
    result_collector_if.slave  bus
);
    collector_state_t  state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rv_q, rv_d;
    logic              done_q, done_d;
    logic              ready;
    logic              xfer;
`ifdef RESULT_CHECKSUM_EN
    logic [DATA_W-1:0] cks_q, cks_d;
`endif

    assign ready = (state_q == COLLECT);
    assign xfer  = bus.data_valid && ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            rv_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
            cks_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rv_q    <= rv_d;
            done_q  <= done_d;
`ifdef RESULT_CHECKSUM_EN
            cks_q   <= cks_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rv_d    = rv_q;
        done_d  = 1'b0;
`ifdef RESULT_CHECKSUM_EN
        cks_d   = cks_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = COLLECT;
                    count_d = '0;
                    rv_d    = 1'b0;
`ifdef RESULT_CHECKSUM_EN
                    cks_d   = '0;
`endif
                end
            end
            COLLECT: begin
                // start is deliberately not looked at here
                if (xfer) begin
                    count_d = count_q + 1'b1;
`ifdef RESULT_CHECKSUM_EN
                    cks_d   = cks_q ^ bus.data_in;
`endif
                    if (count_q == CNT_W'(CHUNKS - 1)) begin
                        state_d = DONE;
                        rv_d    = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    result_regfile #(
        .DATA_W (DATA_W),
        .CHUNKS (CHUNKS)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .we_i      (xfer),
        .waddr_i   (count_q[ADDR_W-1:0]),
        .wdata_i   (bus.data_in),
        .raddr_i   (bus.rd_addr),
        .rd_data_o (bus.rd_data),
        .flat_o    (bus.result_flat)
    );

    assign bus.data_ready   = ready;
    assign bus.busy         = ready;
    assign bus.chunk_count  = count_q;
    assign bus.collect_done = done_q;
    assign bus.result_valid = rv_q;
    assign bus.dbg_state    = state_q;
`ifdef RESULT_CHECKSUM_EN
    assign bus.checksum     = cks_q;
`endif
endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector against a chunk-list reference model.
module tb_result_collector;
    import result_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    result_collector_if bus ();

    result_collector dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what storage holds and what the current result has seen
    logic [63:0] m_mem [8];
    int          m_cnt;
    logic [63:0] m_cks;
    logic        m_rv;
    logic [63:0] vec [8];

    function automatic logic [511:0] exp_flat();
        logic [511:0] f;
        for (int k = 0; k < 8; k++) f[k*64 +: 64] = m_mem[k];
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_mem[k] = '0;
        m_cnt = 0;
        m_cks = '0;
        m_rv  = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        m_cnt = 0;
        m_cks = '0;
        m_rv  = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.chunk_count !== 4'd0 || bus.result_valid !== 1'b0) begin
            failures++;
            $display("FAIL start_entry busy=%b count=%0d rv=%b required busy=1 count=0 rv=0",
                     bus.busy, bus.chunk_count, bus.result_valid);
        end
    endtask

    task automatic send_chunk(input logic [63:0] d, input int gap, input logic st);
        int n;
        n = 0;
        while (bus.data_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.data_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_timeout data_ready=%b required 1", bus.data_ready);
        end
        bus.data_valid = 1'b1;
        bus.data_in    = d;
        bus.start      = st;
        tick();
        bus.data_valid = 1'b0;
        bus.start      = 1'b0;
        bus.data_in    = {$urandom, $urandom};
        if (m_cnt < 8) begin
            m_mem[m_cnt] = d;
            m_cnt++;
            m_cks ^= d;
            if (m_cnt == 8) m_rv = 1'b1;
        end
        checks++;
        if (bus.chunk_count !== 4'(m_cnt)) begin
            failures++;
            $display("FAIL xfer_count got=%0d required=%0d", bus.chunk_count, m_cnt);
        end
        checks++;
        if (bus.collect_done !== m_rv || bus.result_valid !== m_rv) begin
            failures++;
            $display("FAIL xfer_done done=%b rv=%b required both=%b",
                     bus.collect_done, bus.result_valid, m_rv);
        end
        for (int g = 0; g < gap; g++) begin
            tick();
            checks++;
            if (bus.chunk_count !== 4'(m_cnt) || bus.collect_done !== 1'b0) begin
                failures++;
                $display("FAIL gap_hold count=%0d done=%b required count=%0d done=0",
                         bus.chunk_count, bus.collect_done, m_cnt);
            end
        end
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.start      = 1'b1;
        bus.data_valid = 1'b1;
        bus.data_in    = {$urandom, $urandom};
        bus.rd_addr    = 3'($urandom_range(0, 7));
        tick();
        tick();
        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.data_valid = 1'b0;
        model_reset();
        checks++;
        if (bus.data_ready !== 1'b0 || bus.busy !== 1'b0 || bus.chunk_count !== 4'd0 ||
            bus.collect_done !== 1'b0 || bus.result_valid !== 1'b0 || bus.dbg_state !== IDLE) begin
            failures++;
            $display("FAIL reset_ctrl ready=%b busy=%b count=%0d done=%b rv=%b state=%0d required all zero/IDLE",
                     bus.data_ready, bus.busy, bus.chunk_count, bus.collect_done,
                     bus.result_valid, bus.dbg_state);
        end
        checks++;
        if (bus.rd_data !== 64'd0 || bus.result_flat !== 512'd0) begin
            failures++;
            $display("FAIL reset_data rd_data=%h required 0, flat nonzero", bus.rd_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] lit;
        do_start();
        for (int k = 0; k < 8; k++) send_chunk(vec[k], 0, 1'b0);
        lit = {vec[7], vec[6], vec[5], vec[4], vec[3], vec[2], vec[1], vec[0]};
        checks++;
        if (bus.result_flat !== lit) begin
            failures++;
            $display("FAIL b2b_flat got=%h required=%h", bus.result_flat, lit);
        end
        checks++;
        if (bus.result_flat[511:448] !== 64'hDEADBEEFCAFEBABE) begin
            failures++;
            $display("FAIL b2b_msb got=%h required=deadbeefcafebabe", bus.result_flat[511:448]);
        end
        tick();
        checks++;
        if (bus.collect_done !== 1'b0 || bus.result_valid !== 1'b1 || bus.dbg_state !== DONE ||
            bus.chunk_count !== 4'd8 || bus.data_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_hold done=%b rv=%b state=%0d count=%0d ready=%b required 0/1/DONE/8/0",
                     bus.collect_done, bus.result_valid, bus.dbg_state, bus.chunk_count, bus.data_ready);
        end
    endtask

    task automatic test_readback();
        bus.rd_addr = 3'd7;
        tick();
        checks++;
        if (bus.rd_data !== 64'hDEADBEEFCAFEBABE) begin
            failures++;
            $display("FAIL rd_addr7 got=%h required=deadbeefcafebabe", bus.rd_data);
        end
        for (int i = 0; i < 6; i++) begin
            int a;
            a = $urandom_range(0, 7);
            bus.rd_addr = 3'(a);
            tick();
            checks++;
            if (bus.rd_data !== m_mem[a]) begin
                failures++;
                $display("FAIL rd_rand addr=%0d got=%h required=%h", a, bus.rd_data, m_mem[a]);
            end
        end
`ifdef RESULT_CHECKSUM_EN
        checks++;
        if (bus.checksum !== (vec[0]^vec[1]^vec[2]^vec[3]^vec[4]^vec[5]^vec[6]^vec[7])) begin
            failures++;
            $display("FAIL checksum got=%h required=%h", bus.checksum, m_cks);
        end
`endif
    endtask

    task automatic test_gaps();
        logic [511:0] prev;
        prev = exp_flat();
        do_start();
        checks++;
        if (bus.result_flat !== prev) begin
            failures++;
            $display("FAIL restart_keeps_storage got=%h required=%h", bus.result_flat, prev);
        end
        for (int k = 0; k < 8; k++) send_chunk(vec[k], 2, 1'b0);
        checks++;
        if (bus.result_flat !== exp_flat()) begin
            failures++;
            $display("FAIL gaps_flat got=%h required=%h", bus.result_flat, exp_flat());
        end
    endtask

    task automatic test_no_ready();
        bus.data_valid = 1'b1;
        bus.data_in    = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.data_ready !== 1'b0 || bus.chunk_count !== 4'd8 || bus.result_flat !== exp_flat()) begin
                failures++;
                $display("FAIL done_blocks ready=%b count=%0d required ready=0 count=8 storage unchanged",
                         bus.data_ready, bus.chunk_count);
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.data_ready !== 1'b0 || bus.chunk_count !== 4'd0 || bus.result_flat !== 512'd0) begin
                failures++;
                $display("FAIL idle_blocks ready=%b count=%0d required ready=0 count=0 storage zero",
                         bus.data_ready, bus.chunk_count);
            end
        end
        bus.data_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_start();
        for (int k = 0; k < 3; k++) send_chunk({$urandom, $urandom}, 0, 1'b0);
        reset     = 1'b1;
        bus.start = 1'b1;
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        model_reset();
        checks++;
        if (bus.chunk_count !== 4'd0 || bus.busy !== 1'b0 || bus.result_flat !== 512'd0) begin
            failures++;
            $display("FAIL reset_mid count=%0d busy=%b required count=0 busy=0 storage zero",
                     bus.chunk_count, bus.busy);
        end
        do_start();
        for (int k = 0; k < 8; k++) send_chunk({$urandom, $urandom}, $urandom_range(0, 2), 1'b0);
        checks++;
        if (bus.result_flat !== exp_flat()) begin
            failures++;
            $display("FAIL reset_mid_flat got=%h required=%h", bus.result_flat, exp_flat());
        end
    endtask

    task automatic test_start_ignored();
        do_start();
        for (int k = 0; k < 4; k++) send_chunk(vec[k], 0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.chunk_count !== 4'd4 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL start_in_collect count=%0d busy=%b required count=4 busy=1",
                     bus.chunk_count, bus.busy);
        end
        bus.rd_addr = 3'd2;
        tick();
        checks++;
        if (bus.rd_data !== m_mem[2]) begin
            failures++;
            $display("FAIL rd_collect got=%h required=%h", bus.rd_data, m_mem[2]);
        end
        for (int k = 4; k < 7; k++) send_chunk(vec[k], 0, 1'b0);
        send_chunk(vec[7], 0, 1'b1);
        tick();
        checks++;
        if (bus.dbg_state !== DONE || bus.result_valid !== 1'b1 || bus.result_flat !== exp_flat()) begin
            failures++;
            $display("FAIL start_with_last state=%0d rv=%b required DONE rv=1 full result",
                     bus.dbg_state, bus.result_valid);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            do_start();
            for (int k = 0; k < 8; k++) send_chunk({$urandom, $urandom}, $urandom_range(0, 3), 1'b0);
            checks++;
            if (bus.result_flat !== exp_flat()) begin
                failures++;
                $display("FAIL rand_flat round=%0d got=%h required=%h", r, bus.result_flat, exp_flat());
            end
`ifdef RESULT_CHECKSUM_EN
            checks++;
            if (bus.checksum !== m_cks) begin
                failures++;
                $display("FAIL rand_checksum round=%0d got=%h required=%h", r, bus.checksum, m_cks);
            end
`endif
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.data_valid = 1'b0;
        bus.data_in    = '0;
        bus.rd_addr    = '0;
        vec[0] = 64'h1122334455667788;
        vec[1] = 64'h0FEDCBA987654321;
        vec[2] = 64'h2468ACE0FEDCBA98;
        vec[3] = 64'h13579BDFDEADBEEF;
        vec[4] = 64'h123456789ABCDEF0;
        vec[5] = 64'h99AABBCCDDEEF00D;
        vec[6] = 64'h1122334455667788;
        vec[7] = 64'hDEADBEEFCAFEBABE;
        model_reset();

        test_reset();
        test_back_to_back();
        test_readback();
        test_gaps();
        test_no_ready();
        test_reset_mid();
        test_start_ignored();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 Parameter DATA_W, default 64: width of one result chunk.
REQ-002 Parameter CHUNKS, default 8: chunks per matrix result; CHUNKS*DATA_W = 512.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  arms collection of a new matrix result.
REQ-006 data_in  in  DATA_W  chunk from the output datapath (final_data_out).
REQ-007 data_valid  in  1  data_in holds a valid chunk.
REQ-008 data_ready  out  1  collector accepts a chunk this cycle.
REQ-009 chunk_count  out  4  number of chunks accepted for the current result.
REQ-010 busy  out  1  high while in COLLECT.
REQ-011 collect_done  out  1  one-cycle pulse when chunk CHUNKS is accepted.
REQ-012 result_valid  out  1  level; stored result is complete and stable.
REQ-013 result_flat  out  CHUNKS*DATA_W  all stored chunks; chunk k in bits [64k+63:64k].
REQ-014 rd_addr  in  3  chunk read index.
REQ-015 rd_data  out  DATA_W  registered copy of stored chunk rd_addr.

Function
REQ-016 The FSM SHALL have three states: IDLE, COLLECT, DONE.
REQ-017 IDLE -> COLLECT on start; DONE -> COLLECT on start; start in COLLECT is ignored.
REQ-018 Entering COLLECT SHALL clear chunk_count to 0 and result_valid to 0; stored chunks are not cleared.
REQ-019 data_ready SHALL be 1 only in COLLECT; it is a registered-state decode with no combinational path from data_valid.
REQ-020 A transfer occurs on a rising edge with data_valid && data_ready; data_in is written to entry chunk_count and chunk_count increments.
REQ-021 data_valid without data_ready SHALL leave storage and chunk_count unchanged; the chunk is not consumed.
REQ-022 The transfer that makes chunk_count reach CHUNKS SHALL move the FSM to DONE and pulse collect_done for exactly one cycle, aligned with result_valid rising.
REQ-023 In DONE: data_ready=0, chunk_count holds CHUNKS, result_valid=1 until the next start.
REQ-024 rd_data SHALL update one cycle after rd_addr, in every state.
REQ-025 A start coincident with a transfer in DONE SHALL be impossible (data_ready=0); start coincident with the final transfer in COLLECT is ignored.

Reset
REQ-026 Reset SHALL force IDLE, chunk_count=0, data_ready=0, busy=0, collect_done=0, result_valid=0, rd_data=0, and all stored chunks to 0.
REQ-027 Reset asserted mid-COLLECT SHALL discard the partial result; reset has priority over start and transfers.

Configuration
REQ-028 Macro RESULT_CHECKSUM_EN: when defined, add output checksum [DATA_W-1:0], the XOR of all chunks accepted since the last start, cleared on start and reset and valid when result_valid=1.
REQ-029 Without RESULT_CHECKSUM_EN the checksum port and logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 A shared package result_pkg SHALL hold DATA_W, CHUNKS, and the state enum typedef collector_state_t {IDLE, COLLECT, DONE}.
REQ-031 Chunk storage SHALL be one sub-module, result_regfile (CHUNKS x DATA_W, one write port, one registered read port, flat output).

Verification
REQ-032 Reset, start, then 8 back-to-back valid chunks 1122334455667788, 0FEDCBA987654321, 2468ACE0FEDCBA98, 13579BDFDEADBEEF, 123456789ABCDEF0, 99AABBCCDDEEF00D, 1122334455667788, DEADBEEFCAFEBABE -> result_flat = the 512-bit concatenation with DEADBEEFCAFEBABE in the MSBs; collect_done pulses once on the 8th edge.
REQ-033 Same chunks with data_valid gaps of 2 idle cycles between them -> identical result_flat; chunk_count steps 0..8 only on valid cycles.
REQ-034 data_valid held high in IDLE and DONE with data_in=FFFF_FFFF_FFFF_FFFF -> data_ready=0, storage unchanged.
REQ-035 Reset after 3 of 8 chunks, then a fresh start and 8 chunks -> chunk_count restarts at 0, and the final result contains only the new chunks.
REQ-036 After DONE, rd_addr=7 -> rd_data=DEADBEEFCAFEBABE one cycle later; with RESULT_CHECKSUM_EN, checksum = XOR of the 8 chunks above.
REQ-037 Start pulsed during COLLECT after 4 chunks -> ignored; collection completes after 4 more chunks.
